// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types, widths and helpers for the 4-requester round-robin mux arbiter.
//   state_t       : arbiter FSM states (IDLE = no owner, GRANT = owner is sel)
//   NUM_REQ/SEL_W : requester count and select width
//   onehot_to_idx : binary index of a one-hot (or zero) 4-bit grant
package mux_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE, GRANT} state_t;
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin search over four requests.
//   req      : request vector
//   ptr      : index with highest priority; search wraps 3 -> 0
//   excl_en  : when high, request excl_idx is ignored
//   excl_idx : requester to ignore
//   found    : some eligible request exists
//   idx      : first eligible request at or after ptr (ptr when none)
module rr_pick4 import mux_arb_pkg::*; (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic               excl_en,
    input  logic [SEL_W-1:0]   excl_idx,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);
    logic [NUM_REQ-1:0] cand;
    always_comb begin
        cand = req & ~(excl_en ? (NUM_REQ'(1) << excl_idx) : '0);
        found = |cand;
        idx = ptr;
        // walk from farthest to nearest so the nearest match overrides
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (cand[ptr + SEL_W'(k)]) idx = ptr + SEL_W'(k);
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one 4:1 mux between four requesters.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   req  : request vector, bit i = requester i wants the mux
//   gnt  : registered one-hot grant, zero when idle
//   sel  : registered mux select, index of the granted requester
//   busy : registered, high whenever gnt is nonzero
module mux4_rr_arbiter import mux_arb_pkg::*; #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy
);
    state_t             state, state_n;
    logic [SEL_W-1:0]   ptr, ptr_n, owner, idx, sel_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic               busy_n, own_req, others, timeout, found, take;

    assign owner = onehot_to_idx(gnt);
    assign own_req = (state == GRANT) && req[owner];
    assign others = |(req & ~gnt);
    // >= rather than == so a count that saturated during a solo hold still times out
    assign timeout = (MAX_HOLD != 0) && others && (cnt >= CNT_W'(MAX_HOLD));
    assign take = found && (state == IDLE || !own_req || timeout);

    // the current owner is never its own successor
    rr_pick4 u_pick (
        .req      (req),
        .ptr      (ptr),
        .excl_en  (state == GRANT),
        .excl_idx (owner),
        .found    (found),
        .idx      (idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            busy  <= busy_n;
        end
    end

    always_comb begin
        state_n = (own_req || found) ? GRANT : IDLE;
    end

    always_comb begin
        gnt_n  = take ? NUM_REQ'(1) << idx : (own_req ? gnt : '0);
        sel_n  = take ? idx : sel;
        busy_n = |gnt_n;
        ptr_n  = take ? idx + SEL_W'(1) : ptr;
        cnt_n  = take ? CNT_W'(1) : own_req ? ((&cnt) ? cnt : cnt + CNT_W'(1)) : '0;
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed and randomized checks of mux4_rr_arbiter against a behavioural model.
module tb_mux4_rr_arbiter;
    localparam int M = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    int n_tests = 0;
    int n_fail = 0;
    int m_owner = -1;
    int m_ptr = 0;
    int m_hold = 0;
    int m_sel = 0;
    int waits[4] = '{0, 0, 0, 0};
    int max_wait = 0;

    mux4_rr_arbiter #(.MAX_HOLD(M), .CNT_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int start, input int excl);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rs);
        int w;
        int ex;
        logic [3:0] rest;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
        end else begin
            rest = (m_owner >= 0) ? r & ~(4'b0001 << m_owner) : r;
            if (m_owner >= 0 && r[m_owner] && !(M > 0 && rest != 0 && m_hold >= M)) begin
                m_hold = (m_hold < 15) ? m_hold + 1 : 15;
            end else begin
                ex = (m_owner >= 0 && r[m_owner]) ? m_owner : -1;
                w = search(r, m_ptr, ex);
                if (w >= 0) begin
                    m_owner = w; m_ptr = (w + 1) % 4; m_hold = 1; m_sel = w;
                end else begin
                    m_owner = -1; m_hold = 0;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            waits[i] = (!rs && r[i] && m_owner != i) ? waits[i] + 1 : 0;
            if (waits[i] > max_wait) max_wait = waits[i];
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic rs);
        logic [3:0] eg;
        @(negedge clk);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        eg = (m_owner < 0) ? 4'b0000 : 4'b0001 << m_owner;
        check("gnt", 32'(gnt), 32'(eg));
        check("sel", 32'(sel), 32'(m_sel));
        check("busy", 32'(busy), 32'(m_owner >= 0));
    endtask

    initial begin
        logic [3:0] r;
        // reset held with all requests present
        cycle(4'b1111, 1'b1);
        check("rst_gnt", 32'(gnt), 32'h0);
        cycle(4'b1111, 1'b1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        cycle(4'b1111, 1'b0);
        check("first_gnt", 32'(gnt), 32'h1);
        // owner drops its bit each cycle: strict rotation, never idle
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1111 & ~gnt, 1'b0);
            check("rot_gnt", 32'(gnt), 32'(4'b0001 << ((i + 1) % 4)));
        end
        // hold timeout
        cycle(4'b0000, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cycle(4'b0011, 1'b0);
            check("hold_gnt", 32'(gnt), (i >= 4 && i < 8) ? 32'h2 : 32'h1);
        end
        // sole requester keeps the grant indefinitely
        for (int i = 0; i < 20; i++) begin
            cycle(4'b0100, 1'b0);
            check("solo_gnt", 32'(gnt), 32'h4);
            check("solo_sel", 32'(sel), 32'h2);
        end
        cycle(4'b0000, 1'b0);
        check("solo_idle", 32'(busy), 32'h0);
        check("solo_sel_keep", 32'(sel), 32'h2);
        // simultaneous release by owner 1 and request by 3, pointer at 2
        cycle(4'b0000, 1'b1);
        cycle(4'b0010, 1'b0);
        cycle(4'b1000, 1'b0);
        check("simul_gnt", 32'(gnt), 32'h8);
        check("simul_sel", 32'(sel), 32'h3);
        // reset mid-grant
        cycle(4'b0000, 1'b1);
        cycle(4'b0010, 1'b0);
        check("mid_pre", 32'(gnt), 32'h2);
        cycle(4'b1010, 1'b1);
        check("mid_rst", 32'(gnt), 32'h0);
        cycle(4'b1010, 1'b0);
        check("mid_after", 32'(gnt), 32'h2);
        // randomized sticky requests with occasional reset
        cycle(4'b0000, 1'b1);
        max_wait = 0;
        r = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            cycle(r, $urandom_range(99) == 0);
        end
        check("starve", 32'(max_wait <= 3 * M + 1), 32'h1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
